beam_weight_sequencer: RTL and testbench

- Owns the four 5-bit beamforming weights (w_cos_1, w_sin_1, w_cos_2, w_sin_2) that feed the two-beam phase-shift/combine datapath.
- Accepts host weight writes through a valid/ready port and can also run an autonomous angle sweep on one beam from an internal 16-entry cos/sin table.
- All weight changes are double-buffered: shadow to active only on a frame_tick strobe, so the datapath never sees a half-updated cos/sin pair.

---
 rtl/beam_weight_sequencer.sv | 152 +++++++++++++++
 tb/tb_beam_weight_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/beam_weight_sequencer.sv
// beam_weight_sequencer: double-buffered two-beam cos/sin weight owner with host writes and table-driven angle sweep.
// Optional WEIGHT_SYM_CLAMP_EN: host-written most-negative weights are stored as -(2^(W-1)-1).
module beam_weight_sequencer #(
    parameter int W_BITS  = 5,
    parameter int DWELL_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic                     cfg_beam,
    input  logic signed [W_BITS-1:0] cfg_cos,
    input  logic signed [W_BITS-1:0] cfg_sin,
    input  logic                     sweep_start,
    input  logic                     sweep_stop,
    input  logic                     sweep_beam,
    input  logic [DWELL_W-1:0]       dwell_cycles,
    input  logic                     frame_tick,
    output logic signed [W_BITS-1:0] w_cos_1,
    output logic signed [W_BITS-1:0] w_sin_1,
    output logic signed [W_BITS-1:0] w_cos_2,
    output logic signed [W_BITS-1:0] w_sin_2,
    output logic [3:0]               sweep_idx,
    output logic                     sweep_active,
    output logic [1:0]               pending
);
    typedef enum logic [1:0] {IDLE, WAIT_TICK, DWELL} state_t;

    localparam logic signed [W_BITS-1:0] COS_T [16] = '{
        5'sd15, 5'sd14, 5'sd11, 5'sd6, 5'sd0, -5'sd6, -5'sd11, -5'sd14,
        -5'sd15, -5'sd14, -5'sd11, -5'sd6, 5'sd0, 5'sd6, 5'sd11, 5'sd14};
    localparam logic signed [W_BITS-1:0] SIN_T [16] = '{
        5'sd0, 5'sd6, 5'sd11, 5'sd14, 5'sd15, 5'sd14, 5'sd11, 5'sd6,
        5'sd0, -5'sd6, -5'sd11, -5'sd14, -5'sd15, -5'sd14, -5'sd11, -5'sd6};
    localparam logic signed [W_BITS-1:0] W_MIN   = {1'b1, {(W_BITS-1){1'b0}}};
    localparam logic signed [W_BITS-1:0] W_CLAMP = {1'b1, {(W_BITS-2){1'b0}}, 1'b1};
    localparam logic signed [W_BITS-1:0] W_ONE   = {1'b0, {(W_BITS-1){1'b1}}};

    state_t                     r_state, w_nstate;
    logic signed [W_BITS-1:0]   r_sh_cos [2];
    logic signed [W_BITS-1:0]   r_sh_sin [2];
    logic signed [W_BITS-1:0]   r_act_cos [2];
    logic signed [W_BITS-1:0]   r_act_sin [2];
    logic [1:0]                 r_pending;
    logic [3:0]                 r_idx;
    logic                       r_beam;
    logic                       r_ready;
    logic [DWELL_W-1:0]         r_dwell;
    logic [DWELL_W-1:0]         r_cnt;
    logic                       w_xfer, w_stop, w_start, w_adv, w_arm;
    logic [1:0]                 w_commit;
    logic [3:0]                 w_idx_nx;
    logic signed [W_BITS-1:0]   w_cos_in, w_sin_in;

`ifdef WEIGHT_SYM_CLAMP_EN
    assign w_cos_in = (cfg_cos == W_MIN) ? W_CLAMP : cfg_cos;
    assign w_sin_in = (cfg_sin == W_MIN) ? W_CLAMP : cfg_sin;
`else
    assign w_cos_in = cfg_cos;
    assign w_sin_in = cfg_sin;
`endif

    assign cfg_ready    = r_ready & (r_state == IDLE);
    assign w_xfer       = cfg_valid & cfg_ready;
    assign w_stop       = sweep_stop & (r_state != IDLE);
    assign w_start      = sweep_start & ~sweep_stop & (r_state == IDLE);
    assign w_arm        = (r_state == WAIT_TICK) & frame_tick & ~w_stop;
    assign w_adv        = (r_state == DWELL) & (r_cnt == DWELL_W'(1)) & ~w_stop;
    assign w_idx_nx     = r_idx + 4'd1;
    // A stop in the commit cycle suppresses the swept beam's commit only
    assign w_commit[0]  = frame_tick & r_pending[0] & ~(w_stop & ~r_beam);
    assign w_commit[1]  = frame_tick & r_pending[1] & ~(w_stop & r_beam);

    assign w_cos_1      = r_act_cos[0];
    assign w_sin_1      = r_act_sin[0];
    assign w_cos_2      = r_act_cos[1];
    assign w_sin_2      = r_act_sin[1];
    assign sweep_idx    = r_idx;
    assign sweep_active = (r_state != IDLE);
    assign pending      = r_pending;

    always_comb begin
        w_nstate = r_state;
        if (w_stop)
            w_nstate = IDLE;
        else if (w_start)
            w_nstate = WAIT_TICK;
        else if (w_arm)
            w_nstate = DWELL;
        else if (w_adv)
            w_nstate = WAIT_TICK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_nstate;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_sh_cos[b]  <= W_ONE;
                r_sh_sin[b]  <= '0;
                r_act_cos[b] <= W_ONE;
                r_act_sin[b] <= '0;
            end
            r_pending <= '0;
            r_idx     <= '0;
            r_beam    <= 1'b0;
            r_ready   <= 1'b0;
            r_dwell   <= DWELL_W'(1);
            r_cnt     <= '0;
        end else begin
            r_ready <= 1'b1;
            for (int b = 0; b < 2; b++) begin
                if (w_commit[b]) begin
                    r_act_cos[b] <= r_sh_cos[b];
                    r_act_sin[b] <= r_sh_sin[b];
                    r_pending[b] <= 1'b0;
                end
            end
            if (w_stop)
                r_pending[r_beam] <= 1'b0;
            // Later assignments win: a write in a tick cycle stays pending for the next tick
            if (w_xfer) begin
                r_sh_cos[cfg_beam]  <= w_cos_in;
                r_sh_sin[cfg_beam]  <= w_sin_in;
                r_pending[cfg_beam] <= 1'b1;
            end
            if (w_start) begin
                r_beam                <= sweep_beam;
                r_dwell               <= (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
                r_idx                 <= '0;
                r_sh_cos[sweep_beam]  <= COS_T[0];
                r_sh_sin[sweep_beam]  <= SIN_T[0];
                r_pending[sweep_beam] <= 1'b1;
            end
            if (w_arm)
                r_cnt <= r_dwell;
            else if (r_state == DWELL)
                r_cnt <= r_cnt - DWELL_W'(1);
            if (w_adv) begin
                r_idx             <= w_idx_nx;
                r_sh_cos[r_beam]  <= COS_T[w_idx_nx];
                r_sh_sin[r_beam]  <= SIN_T[w_idx_nx];
                r_pending[r_beam] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_beam_weight_sequencer.sv
// tb_beam_weight_sequencer: directed self-checking bench for beam_weight_sequencer.
// Clamp expectation follows WEIGHT_SYM_CLAMP_EN when the bench is built with it.
module tb_beam_weight_sequencer;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0, cfg_ready, cfg_beam = 1'b0;
    logic signed [4:0] cfg_cos = '0, cfg_sin = '0;
    logic              sweep_start = 1'b0, sweep_stop = 1'b0, sweep_beam = 1'b0;
    logic [15:0]       dwell_cycles = '0;
    logic              frame_tick = 1'b0;
    logic signed [4:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
    logic [3:0]        sweep_idx;
    logic              sweep_active;
    logic [1:0]        pending;
    int checks = 0;
    int failures = 0;
    int tc [16] = '{15, 14, 11, 6, 0, -6, -11, -14, -15, -14, -11, -6, 0, 6, 11, 14};
    int ts [16] = '{0, 6, 11, 14, 15, 14, 11, 6, 0, -6, -11, -14, -15, -14, -11, -6};

    beam_weight_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_beam(cfg_beam), .cfg_cos(cfg_cos), .cfg_sin(cfg_sin),
        .sweep_start(sweep_start), .sweep_stop(sweep_stop), .sweep_beam(sweep_beam),
        .dwell_cycles(dwell_cycles), .frame_tick(frame_tick),
        .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2),
        .sweep_idx(sweep_idx), .sweep_active(sweep_active), .pending(pending));

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic beam, input int c, input int s, input logic tick);
        cfg_valid = 1'b1; cfg_beam = beam; cfg_cos = 5'(c); cfg_sin = 5'(s); frame_tick = tick;
        step(1);
        cfg_valid = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic tick;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_low got=%b exp=0", cfg_ready); end
        checks++; if (w_cos_1 !== 15 || w_sin_1 !== 0) begin failures++; $display("FAIL rst_in_w1 got=%0d,%0d exp=15,0", w_cos_1, w_sin_1); end
        @(posedge clk); #1 rst_n = 1'b1;
        step(2);
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cfg_ready); end
        checks++; if (pending !== 2'b00) begin failures++; $display("FAIL rst_pending got=%b exp=00", pending); end
        checks++; if (w_cos_2 !== 15 || w_sin_2 !== 0) begin failures++; $display("FAIL rst_w2 got=%0d,%0d exp=15,0", w_cos_2, w_sin_2); end
        checks++; if (sweep_idx !== 4'd0 || sweep_active !== 1'b0) begin failures++; $display("FAIL rst_sweep got=%0d,%b exp=0,0", sweep_idx, sweep_active); end
        step(5);
        checks++; if (w_cos_1 !== 15 || w_sin_1 !== 0) begin failures++; $display("FAIL rst_hold_w1 got=%0d,%0d exp=15,0", w_cos_1, w_sin_1); end
    endtask

    task automatic test_write_commit;
        write(1'b1, -6, 11, 1'b0);
        step(20);
        checks++; if (pending !== 2'b10) begin failures++; $display("FAIL wr_pending got=%b exp=10", pending); end
        checks++; if (w_cos_2 !== 15 || w_sin_2 !== 0) begin failures++; $display("FAIL wr_no_tick got=%0d,%0d exp=15,0", w_cos_2, w_sin_2); end
        frame_tick = 1'b1;
        #2;
        checks++; if (w_cos_2 !== 15) begin failures++; $display("FAIL wr_tick_cycle got=%0d exp=15", w_cos_2); end
        step(1);
        frame_tick = 1'b0;
        checks++; if (w_cos_2 !== -6 || w_sin_2 !== 11) begin failures++; $display("FAIL wr_commit got=%0d,%0d exp=-6,11", w_cos_2, w_sin_2); end
        checks++; if (pending !== 2'b00) begin failures++; $display("FAIL wr_pending_clr got=%b exp=00", pending); end
        checks++; if (w_cos_1 !== 15 || w_sin_1 !== 0) begin failures++; $display("FAIL wr_other_beam got=%0d,%0d exp=15,0", w_cos_1, w_sin_1); end
    endtask

    task automatic test_write_with_tick;
        write(1'b0, 7, 7, 1'b0);
        write(1'b0, 3, 4, 1'b1);
        checks++; if (w_cos_1 !== 7 || w_sin_1 !== 7) begin failures++; $display("FAIL wt_prior got=%0d,%0d exp=7,7", w_cos_1, w_sin_1); end
        checks++; if (pending !== 2'b01) begin failures++; $display("FAIL wt_pending got=%b exp=01", pending); end
        write(1'b0, 1, 2, 1'b0);
        write(1'b0, 3, 4, 1'b0);
        tick();
        checks++; if (w_cos_1 !== 3 || w_sin_1 !== 4) begin failures++; $display("FAIL wt_last_wins got=%0d,%0d exp=3,4", w_cos_1, w_sin_1); end
        checks++; if (pending !== 2'b00) begin failures++; $display("FAIL wt_pending_clr got=%b exp=00", pending); end
    endtask

    task automatic test_sweep;
        sweep_start = 1'b1; sweep_beam = 1'b0; dwell_cycles = 16'd3;
        step(1);
        sweep_start = 1'b0;
        checks++; if (sweep_active !== 1'b1 || cfg_ready !== 1'b0) begin failures++; $display("FAIL sw_start got=%b,%b exp=1,0", sweep_active, cfg_ready); end
        checks++; if (pending !== 2'b01 || sweep_idx !== 4'd0) begin failures++; $display("FAIL sw_load got=%b,%0d exp=01,0", pending, sweep_idx); end
        sweep_start = 1'b1; sweep_beam = 1'b1; dwell_cycles = 16'd50;
        write(1'b1, 9, 9, 1'b0);
        sweep_start = 1'b0;
        checks++; if (pending !== 2'b01 || sweep_idx !== 4'd0) begin failures++; $display("FAIL sw_ignore got=%b,%0d exp=01,0", pending, sweep_idx); end
        for (int k = 0; k < 18; k++) begin
            tick();
            checks++; if (w_cos_1 !== tc[k % 16] || w_sin_1 !== ts[k % 16]) begin failures++; $display("FAIL sw_commit k=%0d got=%0d,%0d exp=%0d,%0d", k, w_cos_1, w_sin_1, tc[k % 16], ts[k % 16]); end
            step(2);
            checks++; if (sweep_idx !== 4'(k % 16) || w_cos_1 !== tc[k % 16]) begin failures++; $display("FAIL sw_dwell k=%0d got=%0d,%0d exp=%0d,%0d", k, sweep_idx, w_cos_1, k % 16, tc[k % 16]); end
            step(7);
            checks++; if (sweep_idx !== 4'((k + 1) % 16) || pending !== 2'b01) begin failures++; $display("FAIL sw_adv k=%0d got=%0d,%b exp=%0d,01", k, sweep_idx, pending, (k + 1) % 16); end
            checks++; if (w_cos_2 !== -6 || w_sin_2 !== 11 || cfg_ready !== 1'b0) begin failures++; $display("FAIL sw_beam2 k=%0d got=%0d,%0d,%b exp=-6,11,0", k, w_cos_2, w_sin_2, cfg_ready); end
        end
        sweep_stop = 1'b1;
        step(1);
        sweep_stop = 1'b0;
        checks++; if (sweep_active !== 1'b0 || pending !== 2'b00 || sweep_idx !== 4'd2) begin failures++; $display("FAIL sw_stop got=%b,%b,%0d exp=0,00,2", sweep_active, pending, sweep_idx); end
        checks++; if (w_cos_1 !== 14 || w_sin_1 !== 6) begin failures++; $display("FAIL sw_stop_hold got=%0d,%0d exp=14,6", w_cos_1, w_sin_1); end
    endtask

    task automatic test_stop_with_tick;
        sweep_start = 1'b1; sweep_beam = 1'b0; dwell_cycles = 16'd0;
        step(1);
        sweep_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (sweep_idx !== 4'(k) || w_cos_1 !== tc[k]) begin failures++; $display("FAIL st_dwell0 k=%0d got=%0d,%0d exp=%0d,%0d", k, sweep_idx, w_cos_1, k, tc[k]); end
            step(1);
            checks++; if (sweep_idx !== 4'(k + 1)) begin failures++; $display("FAIL st_adv k=%0d got=%0d exp=%0d", k, sweep_idx, k + 1); end
            step(2);
        end
        sweep_stop = 1'b1; frame_tick = 1'b1; sweep_start = 1'b1;
        step(1);
        sweep_stop = 1'b0; frame_tick = 1'b0; sweep_start = 1'b0;
        checks++; if (w_cos_1 !== 0 || w_sin_1 !== 15) begin failures++; $display("FAIL st_no_commit got=%0d,%0d exp=0,15", w_cos_1, w_sin_1); end
        checks++; if (sweep_active !== 1'b0 || pending !== 2'b00 || cfg_ready !== 1'b1) begin failures++; $display("FAIL st_idle got=%b,%b,%b exp=0,00,1", sweep_active, pending, cfg_ready); end
        checks++; if (sweep_idx !== 4'd5) begin failures++; $display("FAIL st_idx got=%0d exp=5", sweep_idx); end
        tick();
        checks++; if (w_cos_1 !== 0 || w_sin_1 !== 15) begin failures++; $display("FAIL st_later_tick got=%0d,%0d exp=0,15", w_cos_1, w_sin_1); end
    endtask

    task automatic test_clamp;
        int exp_v;
`ifdef WEIGHT_SYM_CLAMP_EN
        exp_v = -15;
`else
        exp_v = -16;
`endif
        write(1'b1, -16, -16, 1'b0);
        tick();
        checks++; if (w_cos_2 !== exp_v || w_sin_2 !== exp_v) begin failures++; $display("FAIL clamp got=%0d,%0d exp=%0d,%0d", w_cos_2, w_sin_2, exp_v, exp_v); end
        write(1'b1, -15, 5, 1'b0);
        tick();
        checks++; if (w_cos_2 !== -15 || w_sin_2 !== 5) begin failures++; $display("FAIL clamp_passthru got=%0d,%0d exp=-15,5", w_cos_2, w_sin_2); end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_write_with_tick();
        test_sweep();
        test_stop_with_tick();
        test_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
